servo_pwm_decoder: RTL

SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_pwm_decoder_if.sv | 27 ++
 rtl/servo_pwm_decoder_sync_edge.sv | 32 +++
 rtl/servo_pwm_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo timing constants and decoder types, so the PWM encoder and
// decoder agree on pulse widths.
package servo_pkg;

    localparam int CLK_HZ          = 12_000_000;
    localparam int DEF_PW_GLITCH   = 6_000;
    localparam int DEF_PW_MIN      = 12_000;
    localparam int DEF_STEP        = 47;
    localparam int DEF_PW_LONG     = 36_000;
    localparam int DEF_TIMEOUT     = 360_000;

    localparam int CNT_BITS = 19;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        HIGH,
        DRAIN
    } dec_state_t;

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Servo decoder bus: raw PWM input towards the decoder, decoded angle and
// status strobes back out.
interface servo_pwm_decoder_if;

    logic       servo_in;
    logic [7:0] angle;
    logic       valid;
    logic       err;
    logic       lost;

    modport master (
        output servo_in,
        input  angle,
        input  valid,
        input  err,
        input  lost
    );

    modport slave (
        input  servo_in,
        output angle,
        output valid,
        output err,
        output lost
    );

endinterface

// File: rtl/servo_pwm_decoder_sync_edge.sv
// Two-flop synchronizer for the asynchronous servo input, plus a registered
// copy for single-cycle rise/fall strobes.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic s_d;

    // NOTE: non-blocking assignments let each flop sample the previous stage's
    // old value, which is what makes this a real shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= din;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the high width of each pulse, maps it to an
// 8-bit angle without a divider, and flags glitches, over-long pulses and loss.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int PW_GLITCH = DEF_PW_GLITCH,
    parameter int PW_MIN    = DEF_PW_MIN,
    parameter int STEP      = DEF_STEP,
    parameter int PW_LONG   = DEF_PW_LONG,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input logic          clk,
    input logic          rst,
    servo_pwm_decoder_if.slave bus
);

    localparam int PRE_W = (STEP > 1) ? $clog2(STEP) : 1;

    localparam logic [CNT_BITS-1:0] GLITCH_W = CNT_BITS'(PW_GLITCH);
    localparam logic [CNT_BITS-1:0] MIN_W    = CNT_BITS'(PW_MIN);
    localparam logic [CNT_BITS-1:0] LONG_W   = CNT_BITS'(PW_LONG);
    localparam logic [CNT_BITS-1:0] TO_W     = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] TO_M1    = CNT_BITS'(TIMEOUT - 1);
    localparam logic [PRE_W-1:0]    STEP_M1  = PRE_W'(STEP - 1);

    logic s;
    logic rise;
    logic fall;

    dec_state_t           state;
    logic [1:0]           arm_cnt;
    logic [CNT_BITS-1:0]  w_cnt;
    logic [PRE_W-1:0]     pre;
    logic [7:0]           bin;
    logic                 ok_pend;
    logic                 err_pend;
    logic [7:0]           angle_pend;
    logic [7:0]           angle_q;
    logic                 valid_q;
    logic                 err_q;
    logic [CNT_BITS-1:0]  to_cnt;
    logic                 lost_q;

    sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.servo_in),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    // Decisions taken on the fall are staged once more so valid lands three
    // cycles after the first low sample; over-long err fires immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARM;
            arm_cnt    <= 2'd0;
            w_cnt      <= '0;
            pre        <= '0;
            bin        <= 8'd0;
            ok_pend    <= 1'b0;
            err_pend   <= 1'b0;
            angle_pend <= 8'd0;
            angle_q    <= 8'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ok_pend  <= 1'b0;
            err_pend <= 1'b0;
            valid_q  <= ok_pend;
            err_q    <= err_pend;
            if (ok_pend) begin
                angle_q <= angle_pend;
            end

            case (state)
                ARM: begin
                    // Synchronizer flops come out of reset low, so wait until
                    // they carry the real input before trusting s=0.
                    if (arm_cnt != 2'd3) begin
                        arm_cnt <= arm_cnt + 2'd1;
                    end else if (!s) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        w_cnt <= {{(CNT_BITS-1){1'b0}}, 1'b1};
                        pre   <= '0;
                        bin   <= 8'd0;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        state <= IDLE;
                        if (w_cnt < GLITCH_W) begin
                            err_pend <= 1'b1;
                        end else begin
                            ok_pend    <= 1'b1;
                            angle_pend <= bin;
                        end
                    end else begin
                        if (w_cnt == LONG_W) begin
                            state <= DRAIN;
                            err_q <= 1'b1;
                        end
                        if (w_cnt != {CNT_BITS{1'b1}}) begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                        // One angle LSB per STEP high cycles beyond PW_MIN.
                        if (w_cnt >= MIN_W) begin
                            if (pre == STEP_M1) begin
                                pre <= '0;
                                if (bin != 8'hFF) begin
                                    bin <= bin + 8'd1;
                                end
                            end else begin
                                pre <= pre + 1'b1;
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (!s) begin
                        state <= IDLE;
                    end
                end

                default: state <= ARM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            lost_q <= 1'b1;
        end else if (ok_pend) begin
            to_cnt <= '0;
            lost_q <= 1'b0;
        end else begin
            if (to_cnt != TO_W) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt == TO_M1) begin
                lost_q <= 1'b1;
            end
        end
    end

    assign bus.angle = angle_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.lost  = lost_q;

endmodule
